// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register for the Y86 core.
// Holds on stall, loads a NOP bubble on bubble, otherwise captures the
// decode outputs. A sticky ctl_err records any cycle in which stall and
// bubble were requested together; that case is resolved as a stall.
// Optional feature: define ID_EX_PERF_CNT_EN to add saturating
// stall_cnt / bubble_cnt performance counters.
module id_ex_stage #(
    parameter int unsigned               WORD_W    = 32,
    parameter int unsigned               PC_W      = 32,
    parameter int unsigned               STAT_W    = 3,
    parameter logic [7:0]                NOP_ICODE = 8'h10,
    parameter logic [7:0]                RNONE     = 8'h0F,
    parameter logic [STAT_W-1:0]         STAT_BUB  = '0,
    parameter int unsigned               CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 bubble,
    input  logic                 id_valid,
    input  logic [STAT_W-1:0]    id_stat,
    input  logic [7:0]           id_icode,
    input  logic [7:0]           id_ifun,
    input  logic [7:0]           id_rA,
    input  logic [7:0]           id_rB,
    input  logic [WORD_W-1:0]    id_valA,
    input  logic [WORD_W-1:0]    id_valB,
    input  logic [WORD_W-1:0]    id_valC,
    input  logic [PC_W-1:0]      id_valP,
    output logic                 ex_valid,
    output logic [STAT_W-1:0]    ex_stat,
    output logic [7:0]           ex_icode,
    output logic [7:0]           ex_ifun,
    output logic [7:0]           ex_rA,
    output logic [7:0]           ex_rB,
    output logic [WORD_W-1:0]    ex_valA,
    output logic [WORD_W-1:0]    ex_valB,
    output logic [WORD_W-1:0]    ex_valC,
    output logic [PC_W-1:0]      ex_valP,
`ifdef ID_EX_PERF_CNT_EN
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     bubble_cnt,
`endif
    output logic                 ctl_err
);

    // Per-edge action selected by the pipeline-control inputs.
    localparam logic [1:0] MODE_LOAD   = 2'd0;
    localparam logic [1:0] MODE_HOLD   = 2'd1;
    localparam logic [1:0] MODE_BUBBLE = 2'd2;

    logic [1:0] mode_s;

    // A zero-width counter would be meaningless; reject it at elaboration.
    if (CNT_W == 0) begin : g_cnt_w_check
        $error("id_ex_stage: CNT_W must be at least 1");
    end

    // Resolve stall/bubble into a single action; stall wins a conflict.
    always_comb begin
        mode_s = MODE_LOAD;
        if (stall) begin
            mode_s = MODE_HOLD;
        end else if (bubble) begin
            mode_s = MODE_BUBBLE;
        end else begin
            mode_s = MODE_LOAD;
        end
    end

    // Pipeline payload register: reset/bubble load a NOP, hold keeps state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_stat  <= STAT_BUB;
            ex_icode <= NOP_ICODE;
            ex_ifun  <= 8'h00;
            ex_rA    <= RNONE;
            ex_rB    <= RNONE;
            ex_valA  <= '0;
            ex_valB  <= '0;
            ex_valC  <= '0;
            ex_valP  <= '0;
        end else begin
            case (mode_s)
                MODE_HOLD: begin
                    ex_valid <= ex_valid;
                    ex_stat  <= ex_stat;
                    ex_icode <= ex_icode;
                    ex_ifun  <= ex_ifun;
                    ex_rA    <= ex_rA;
                    ex_rB    <= ex_rB;
                    ex_valA  <= ex_valA;
                    ex_valB  <= ex_valB;
                    ex_valC  <= ex_valC;
                    ex_valP  <= ex_valP;
                end
                MODE_LOAD: begin
                    ex_valid <= id_valid;
                    ex_stat  <= id_stat;
                    ex_icode <= id_icode;
                    ex_ifun  <= id_ifun;
                    ex_rA    <= id_rA;
                    ex_rB    <= id_rB;
                    ex_valA  <= id_valA;
                    ex_valB  <= id_valB;
                    ex_valC  <= id_valC;
                    ex_valP  <= id_valP;
                end
                // Bubble, and any unexpected encoding, inject a harmless NOP.
                default: begin
                    ex_valid <= 1'b0;
                    ex_stat  <= STAT_BUB;
                    ex_icode <= NOP_ICODE;
                    ex_ifun  <= 8'h00;
                    ex_rA    <= RNONE;
                    ex_rB    <= RNONE;
                    ex_valA  <= '0;
                    ex_valB  <= '0;
                    ex_valC  <= '0;
                    ex_valP  <= '0;
                end
            endcase
        end
    end

    // Sticky conflict flag: set by simultaneous stall+bubble, cleared by reset only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_err <= 1'b0;
        end else if (stall && bubble) begin
            ctl_err <= 1'b1;
        end else begin
            ctl_err <= ctl_err;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Saturating increment: stays at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    // Count stall edges (conflict edges count as stalls).
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

    // Count edges on which a bubble is actually inserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (bubble && !stall) begin
            bubble_cnt <= sat_inc(bubble_cnt);
        end else begin
            bubble_cnt <= bubble_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (counter tests run only when
// ID_EX_PERF_CNT_EN is defined).
`timescale 1ns/1ps
module tb_id_ex_stage;

    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst, stall, bubble, id_valid;
    logic [2:0]  id_stat;
    logic [7:0]  id_icode, id_ifun, id_rA, id_rB;
    logic [31:0] id_valA, id_valB, id_valC, id_valP;
    logic        ex_valid;
    logic [2:0]  ex_stat;
    logic [7:0]  ex_icode, ex_ifun, ex_rA, ex_rB;
    logic [31:0] ex_valA, ex_valB, ex_valC, ex_valP;
    logic        ctl_err;
`ifdef ID_EX_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, bubble_cnt;
`endif

    int total = 0;
    int bad = 0;

    id_ex_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .bubble(bubble),
        .id_valid(id_valid), .id_stat(id_stat), .id_icode(id_icode),
        .id_ifun(id_ifun), .id_rA(id_rA), .id_rB(id_rB),
        .id_valA(id_valA), .id_valB(id_valB), .id_valC(id_valC),
        .id_valP(id_valP),
        .ex_valid(ex_valid), .ex_stat(ex_stat), .ex_icode(ex_icode),
        .ex_ifun(ex_ifun), .ex_rA(ex_rA), .ex_rB(ex_rB),
        .ex_valA(ex_valA), .ex_valB(ex_valB), .ex_valC(ex_valC),
        .ex_valP(ex_valP),
`ifdef ID_EX_PERF_CNT_EN
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
        .ctl_err(ctl_err)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic payload(input logic [7:0] icode, input logic [7:0] rA,
                           input logic [31:0] valA, input logic [31:0] valC,
                           input logic [31:0] valP, input logic [2:0] stat,
                           input logic valid);
        id_icode = icode; id_ifun = 8'h01; id_rA = rA; id_rB = 8'h03;
        id_valA = valA; id_valB = 32'hB0B0_0000; id_valC = valC;
        id_valP = valP; id_stat = stat; id_valid = valid;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b1; bubble = 1'b1;
        for (int i = 0; i < 2; i++) begin
            payload($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 1'b1);
            step();
        end
        total++; if (ex_icode !== 8'h10) begin bad++; $display("FAIL reset_icode got %h exp 10", ex_icode); end
        total++; if (ex_ifun !== 8'h00) begin bad++; $display("FAIL reset_ifun got %h exp 00", ex_ifun); end
        total++; if (ex_rA !== 8'h0F || ex_rB !== 8'h0F) begin bad++; $display("FAIL reset_regs got %h/%h exp 0f/0f", ex_rA, ex_rB); end
        total++; if (ex_valA !== 32'h0 || ex_valB !== 32'h0 || ex_valC !== 32'h0 || ex_valP !== 32'h0) begin
            bad++; $display("FAIL reset_vals got %h %h %h %h exp 0", ex_valA, ex_valB, ex_valC, ex_valP); end
        total++; if (ex_valid !== 1'b0 || ex_stat !== 3'd0) begin bad++; $display("FAIL reset_valid_stat got %b/%0d exp 0/0", ex_valid, ex_stat); end
        total++; if (ctl_err !== 1'b0) begin bad++; $display("FAIL reset_ctl_err got %b exp 0", ctl_err); end
        rst = 1'b0; stall = 1'b0; bubble = 1'b0;
    endtask

    task automatic test_load();
        payload(8'h30, 8'h02, 32'h0000_00AA, 32'h1234_5678, 32'h0000_0100, 3'd1, 1'b1);
        step();
        total++; if (ex_icode !== 8'h30) begin bad++; $display("FAIL load_icode got %h exp 30", ex_icode); end
        total++; if (ex_valC !== 32'h1234_5678) begin bad++; $display("FAIL load_valC got %h exp 12345678", ex_valC); end
        total++; if (ex_valid !== 1'b1 || ex_stat !== 3'd1) begin bad++; $display("FAIL load_valid_stat got %b/%0d exp 1/1", ex_valid, ex_stat); end
        total++; if (ex_rA !== 8'h02 || ex_rB !== 8'h03 || ex_ifun !== 8'h01) begin bad++; $display("FAIL load_regs got %h %h %h exp 02 03 01", ex_rA, ex_rB, ex_ifun); end
        total++; if (ex_valA !== 32'hAA || ex_valB !== 32'hB0B0_0000 || ex_valP !== 32'h100) begin
            bad++; $display("FAIL load_vals got %h %h %h exp aa b0b00000 100", ex_valA, ex_valB, ex_valP); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            payload(8'h40 + 8'(i), 8'h07, 32'h1111_1111, 32'hDEAD_BEEF, 32'h200, 3'd2, 1'b0);
            step();
            total++; if (ex_icode !== 8'h30 || ex_valC !== 32'h1234_5678 || ex_valid !== 1'b1) begin
                bad++; $display("FAIL stall_hold[%0d] got %h/%h/%b exp 30/12345678/1", i, ex_icode, ex_valC, ex_valid); end
        end
        total++; if (ctl_err !== 1'b0) begin bad++; $display("FAIL stall_ctl_err got %b exp 0", ctl_err); end
        stall = 1'b0;
        payload(8'h50, 8'h04, 32'h2222_2222, 32'hCAFE_F00D, 32'h300, 3'd3, 1'b1);
        step();
        total++; if (ex_icode !== 8'h50 || ex_valC !== 32'hCAFE_F00D || ex_rA !== 8'h04) begin
            bad++; $display("FAIL stall_release got %h/%h/%h exp 50/cafef00d/04", ex_icode, ex_valC, ex_rA); end
    endtask

    task automatic test_invalid_load();
        payload(8'h20, 8'h05, 32'h0000_0055, 32'h0, 32'h400, 3'd0, 1'b0);
        step();
        total++; if (ex_valid !== 1'b0 || ex_icode !== 8'h20 || ex_valA !== 32'h55) begin
            bad++; $display("FAIL invalid_load got %b/%h/%h exp 0/20/55", ex_valid, ex_icode, ex_valA); end
    endtask

    task automatic test_bubble();
        bubble = 1'b1;
        payload(8'h60, 8'h01, 32'h9, 32'h77, 32'h500, 3'd1, 1'b1);
        step();
        total++; if (ex_icode !== 8'h10 || ex_rA !== 8'h0F || ex_rB !== 8'h0F || ex_valid !== 1'b0) begin
            bad++; $display("FAIL bubble_nop got %h/%h/%h/%b exp 10/0f/0f/0", ex_icode, ex_rA, ex_rB, ex_valid); end
        total++; if (ex_valC !== 32'h0 || ex_valP !== 32'h0 || ex_stat !== 3'd0 || ex_ifun !== 8'h00) begin
            bad++; $display("FAIL bubble_zero got %h/%h/%0d/%h exp 0", ex_valC, ex_valP, ex_stat, ex_ifun); end
        bubble = 1'b0;
        step();
        total++; if (ex_icode !== 8'h60 || ex_valid !== 1'b1 || ex_rA !== 8'h01) begin
            bad++; $display("FAIL bubble_after got %h/%b/%h exp 60/1/01", ex_icode, ex_valid, ex_rA); end
    endtask

    task automatic test_conflict();
        stall = 1'b1; bubble = 1'b1;
        payload(8'h70, 8'h02, 32'h1, 32'h2, 32'h600, 3'd2, 1'b1);
        step();
        total++; if (ex_icode !== 8'h60 || ex_valid !== 1'b1 || ctl_err !== 1'b1) begin
            bad++; $display("FAIL conflict_hold got %h/%b/%b exp 60/1/1", ex_icode, ex_valid, ctl_err); end
        stall = 1'b0; bubble = 1'b0;
        step();
        total++; if (ctl_err !== 1'b1 || ex_icode !== 8'h70) begin bad++; $display("FAIL conflict_sticky got %b/%h exp 1/70", ctl_err, ex_icode); end
        bubble = 1'b1;
        step();
        total++; if (ctl_err !== 1'b1 || ex_icode !== 8'h10) begin bad++; $display("FAIL conflict_bubble got %b/%h exp 1/10", ctl_err, ex_icode); end
        bubble = 1'b0; rst = 1'b1;
        step();
        total++; if (ctl_err !== 1'b0) begin bad++; $display("FAIL conflict_clear got %b exp 0", ctl_err); end
        rst = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        payload(8'h90, 8'h06, 32'h33, 32'h44, 32'h700, 3'd4, 1'b1);
        step();
        stall = 1'b1; rst = 1'b1;
        step();
        total++; if (ex_icode !== 8'h10 || ex_valid !== 1'b0 || ex_valA !== 32'h0) begin
            bad++; $display("FAIL reset_mid_stall got %h/%b/%h exp 10/0/0", ex_icode, ex_valid, ex_valA); end
        stall = 1'b0; rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            payload(8'h80 + 8'(i), 8'(i), 32'(i * 3), 32'hA000_0000 + 32'(i), 32'h800 + 32'(i * 4), 3'(i), i[0]);
            step();
            total++; if (ex_icode !== 8'h80 + 8'(i) || ex_valC !== 32'hA000_0000 + 32'(i) || ex_valP !== 32'h800 + 32'(i * 4)
                         || ex_valA !== 32'(i * 3) || ex_valid !== i[0] || ex_stat !== 3'(i)) begin
                bad++; $display("FAIL b2b[%0d] got %h/%h/%h/%b exp %h/%h/%h/%b", i, ex_icode, ex_valC, ex_valP, ex_valid,
                                8'h80 + 8'(i), 32'hA000_0000 + 32'(i), 32'h800 + 32'(i * 4), i[0]); end
        end
    endtask

`ifdef ID_EX_PERF_CNT_EN
    task automatic test_perf_cnt();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (stall_cnt !== 4'h0 || bubble_cnt !== 4'h0) begin bad++; $display("FAIL cnt_reset got %h/%h exp 0/0", stall_cnt, bubble_cnt); end
        stall = 1'b1;
        for (int i = 0; i < 20; i++) step();
        stall = 1'b0;
        total++; if (stall_cnt !== 4'hF || bubble_cnt !== 4'h0) begin bad++; $display("FAIL cnt_stall_sat got %h/%h exp f/0", stall_cnt, bubble_cnt); end
        bubble = 1'b1;
        step(); step();
        bubble = 1'b0;
        total++; if (bubble_cnt !== 4'h2 || stall_cnt !== 4'hF) begin bad++; $display("FAIL cnt_bubble got %h/%h exp 2/f", bubble_cnt, stall_cnt); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (stall_cnt !== 4'h0 || bubble_cnt !== 4'h0) begin bad++; $display("FAIL cnt_clear got %h/%h exp 0/0", stall_cnt, bubble_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b1; stall = 1'b0; bubble = 1'b0;
        payload(8'h00, 8'h00, 32'h0, 32'h0, 32'h0, 3'd0, 1'b0);
        test_reset();
        test_load();
        test_stall();
        test_invalid_load();
        test_bubble();
        test_conflict();
        test_reset_mid_stall();
        test_back_to_back();
`ifdef ID_EX_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
